// File: rtl/rr_sched_pkg.sv
// Shared types and the round-robin pick function for the counter scheduler.
package rr_sched_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int unsigned N_REQ_MAX = 8;
  localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request scanning from owner+1, wrapping modulo n.
  function automatic pick_t next_owner(input logic [N_REQ_MAX-1:0] req,
                                       input logic [IDX_W-1:0]     owner,
                                       input int unsigned          n);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned i = 1; i <= N_REQ_MAX; i++) begin
      j = (32'(owner) + i) % n;
      if (i <= n && !p.valid && req[IDX_W'(j)]) begin
        p.valid = 1'b1;
        p.idx   = IDX_W'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next requester after i_owner.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_owner,
  output logic                     o_valid_c,
  output logic [$clog2(N_REQ)-1:0] o_index_c
);

  localparam int unsigned OW = $clog2(N_REQ);

  pick_t w_pick;

  assign w_pick    = next_owner(N_REQ_MAX'(i_req), IDX_W'(i_owner), N_REQ);
  assign o_valid_c = w_pick.valid;
  assign o_index_c = OW'(w_pick.idx);

endmodule

// File: rtl/rr_counter_sched.sv
// Round-robin scheduler sharing one up-counter among N_REQ requesters.
// Define FORMAL_ASSERT_EN to compile in immediate property assertions.
module rr_counter_sched
  import rr_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [WIDTH-1:0]         cnt,
  output logic [WIDTH-1:0]         dbl,
  output logic [WIDTH-1:0]         last_even
);

  localparam int unsigned OW = $clog2(N_REQ);

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_last_even;
  logic             w_pick_valid;
  logic [OW-1:0]    w_pick_idx;
  logic             w_owner_req;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req     (req),
    .i_owner   (r_owner),
    .o_valid_c (w_pick_valid),
    .o_index_c (w_pick_idx)
  );

  assign w_owner_req = req[r_owner];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = BUSY;
      BUSY:    if (!w_owner_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant, owner and counter updates; the counter only advances on release.
  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
          w_owner_nxt = w_pick_idx;
        end
      end
      BUSY: begin
        if (!w_owner_req) begin
          w_gnt_nxt = '0;
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      default: w_gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_owner     <= OW'(N_REQ - 1);
      r_cnt       <= '0;
      r_last_even <= '0;
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!r_cnt[0]) r_last_even <= r_cnt;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state == BUSY);
  assign owner     = r_owner;
  assign cnt       = r_cnt;
  assign dbl       = {r_cnt[WIDTH-2:0], 1'b0};
  assign last_even = r_last_even;

`ifdef FORMAL_ASSERT_EN
  logic r_rel_pend;

  // Set when the owner dropped its request while holding the grant.
  always_ff @(posedge clk) r_rel_pend <= !rst && r_gnt[r_owner] && !w_owner_req;

  always @(posedge clk) begin
    if (!rst) begin
      p_onehot: assert ($onehot0(r_gnt));
      p_dbl:    assert (dbl[0] == 1'b0);
      p_even:   assert (r_last_even[0] == 1'b0);
      p_busy:   assert (busy == (|r_gnt));
      p_hold:   assert (!r_rel_pend || r_gnt == '0);
    end
  end
`else
  // Property checks compiled out.
`endif

endmodule

// File: tb/tb_rr_counter_sched.sv
// Directed self-checking bench for rr_counter_sched (plus a 3-bit instance for wrap).
module tb_rr_counter_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  owner;
  logic [31:0] cnt, dbl, last_even;

  logic        w_rst;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_busy;
  logic [0:0]  w_owner;
  logic [2:0]  w_cnt, w_dbl, w_last_even;

  int checks = 0;
  int errors = 0;

  rr_counter_sched #(.N_REQ(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .busy(busy),
    .owner(owner), .cnt(cnt), .dbl(dbl), .last_even(last_even)
  );

  rr_counter_sched #(.N_REQ(2), .WIDTH(3)) u_w (
    .clk(clk), .rst(w_rst), .req(w_req), .gnt(w_gnt), .busy(w_busy),
    .owner(w_owner), .cnt(w_cnt), .dbl(w_dbl), .last_even(w_last_even)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int idx);
    req = 4'(1 << idx);
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner got %0d exp 3", owner); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    checks++; if (last_even !== 32'd0) begin errors++; $display("FAIL reset_last_even got %0d exp 0", last_even); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL single_owner got %0d exp 0", owner); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy c%0d got %b exp 1", c, busy); end
      tick();
    end
    checks++; if (busy !== 1'b1 || gnt !== 4'b0001) begin errors++; $display("FAIL single_hold got busy=%b gnt=%b exp 1/0001", busy, gnt); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release got gnt=%b busy=%b exp 0000/0", gnt, busy); end
    checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", cnt); end
    checks++; if (dbl !== 32'd2) begin errors++; $display("FAIL single_dbl got %0d exp 2", dbl); end
    tick();
    checks++; if (last_even !== 32'd0) begin errors++; $display("FAIL single_last_even got %0d exp 0", last_even); end
  endtask

  task automatic test_round_robin;
    int exp_idx;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_idx = k % 4;
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'(1 << exp_idx) || owner !== 2'(exp_idx))
        begin errors++; $display("FAIL rr_grant k%0d got gnt=%b owner=%0d exp idx %0d", k, gnt, owner, exp_idx); end
      if (k == 4) begin
        checks++; if (last_even !== 32'd4) begin errors++; $display("FAIL rr_last_even got %0d exp 4", last_even); end
      end
      req[exp_idx] = 1'b0;
      tick();
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle k%0d got gnt=%b busy=%b exp 0000/0", k, gnt, busy); end
      checks++; if (cnt !== 32'(k + 1)) begin errors++; $display("FAIL rr_cnt k%0d got %0d exp %0d", k, cnt, k + 1); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_no_preempt;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL np_grant got gnt=%b owner=%0d exp 0100/2", gnt, owner); end
    req = 4'b0111;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL np_hold1 got %b exp 0100", gnt); end
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL np_hold2 got %b exp 0100", gnt); end
    req = 4'b1001;
    tick();
    checks++; if (gnt !== 4'b0000 || cnt !== 32'd6) begin errors++; $display("FAIL np_release got gnt=%b cnt=%0d exp 0000/6", gnt, cnt); end
    tick();
    checks++; if (gnt !== 4'b1000 || owner !== 2'd3) begin errors++; $display("FAIL np_next3 got gnt=%b owner=%0d exp 1000/3", gnt, owner); end
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0000 || cnt !== 32'd7) begin errors++; $display("FAIL np_release3 got gnt=%b cnt=%0d exp 0000/7", gnt, cnt); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL np_next0 got %b exp 0001", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (cnt !== 32'd8) begin errors++; $display("FAIL np_cnt got %0d exp 8", cnt); end
  endtask

  task automatic test_same_cycle_drop;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_grant got %b exp 0010", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || cnt !== 32'd9)
      begin errors++; $display("FAIL drop_release got gnt=%b busy=%b cnt=%0d exp 0000/0/9", gnt, busy, cnt); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int t = 0; t < 5; t++) txn(0);
    checks++; if (cnt !== 32'd5 || last_even !== 32'd4) begin errors++; $display("FAIL mid_pre got cnt=%0d last_even=%0d exp 5/4", cnt, last_even); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010 || owner !== 2'd1) begin errors++; $display("FAIL mid_grant got gnt=%b owner=%0d exp 0010/1", gnt, owner); end
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_gnt got gnt=%b busy=%b exp 0000/0", gnt, busy); end
    checks++; if (cnt !== 32'd0 || last_even !== 32'd0) begin errors++; $display("FAIL mid_cnt got cnt=%0d last_even=%0d exp 0/0", cnt, last_even); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL mid_owner got %0d exp 3", owner); end
    rst = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap;
    tick();
    w_rst = 1'b0;
    checks++; if (w_owner !== 1'b1 || w_cnt !== 3'd0) begin errors++; $display("FAIL wrap_reset got owner=%0d cnt=%0d exp 1/0", w_owner, w_cnt); end
    for (int t = 0; t < 8; t++) begin
      w_req = 2'b01; tick();
      w_req = 2'b00; tick();
      if (t == 6) begin
        checks++; if (w_cnt !== 3'd7 || w_dbl !== 3'd6 || w_last_even !== 3'd6)
          begin errors++; $display("FAIL wrap_top got cnt=%0d dbl=%0d last_even=%0d exp 7/6/6", w_cnt, w_dbl, w_last_even); end
      end
    end
    checks++; if (w_cnt !== 3'd0 || w_dbl !== 3'd0 || w_last_even !== 3'd6)
      begin errors++; $display("FAIL wrap_zero got cnt=%0d dbl=%0d last_even=%0d exp 0/0/6", w_cnt, w_dbl, w_last_even); end
    tick();
    checks++; if (w_last_even !== 3'd0) begin errors++; $display("FAIL wrap_last_even got %0d exp 0", w_last_even); end
  endtask

  task automatic test_random;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      req = 4'($urandom_range(0, 15));
      tick();
      checks++; if (busy !== (|gnt) || !$onehot0(gnt) || dbl[0] !== 1'b0 || last_even[0] !== 1'b0)
        begin errors++; $display("FAIL random c%0d got busy=%b gnt=%b dbl0=%b le0=%b", c, busy, gnt, dbl[0], last_even[0]); end
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0;
    w_rst = 1'b1; w_req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_same_cycle_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
